// File: rtl/shift_out_6_pkg.sv
// Shared definitions for the 6-bit left-shift serial transmitter and any
// future framed serial blocks that reuse bit_counter.
//   WIDTH_DEFAULT : default word length
//   CNT_W         : counter width for the default word length
//   state_t       : transmitter FSM states
package shift_out_6_pkg;

   localparam int WIDTH_DEFAULT = 6;
   localparam int CNT_W         = $clog2(WIDTH_DEFAULT);

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

endpackage

// File: rtl/shift_out_6_bit_counter.sv
// bit_counter: loadable down-counter with synchronous active-high reset.
// It counts the remaining bits of a frame, minus one.
//   clock      : rising-edge clock
//   reset      : synchronous active-high reset, clears the count
//   load       : load load_value (has priority over dec)
//   load_value : value to load
//   dec        : decrement by one when not loading
//   zero       : count is zero
module bit_counter #(
   parameter int W = 3
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         load,
   input  logic [W-1:0] load_value,
   input  logic         dec,
   output logic         zero
);

   logic [W-1:0] count_q;

   always_ff @(posedge clock) begin
      if (reset)
         count_q <= '0;
      else if (load)
         count_q <= load_value;
      else if (dec)
         count_q <= count_q - W'(1);
   end

   assign zero = (count_q == '0);

endmodule

// File: rtl/shift_out_6.sv
// shift_out_6: parallel-in, serial-out transmitter. It accepts a word through
// a valid/ready handshake and shifts it out MSB first, one bit per clock.
// Back-to-back words are sent with no gap bit. The line idles low.
//   clock      : rising-edge clock
//   reset      : synchronous active-high reset (aborts any word in flight)
//   load_valid : producer has a word on data_in
//   data_in    : word to transmit, sampled only at handshake
//   load_ready : transmitter can accept a word this cycle
//   serial_out : line bit, MSB first
//   busy       : a word is on the line
//   done       : pulse during the last bit of a word
module shift_out_6
   import shift_out_6_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEFAULT
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             load_valid,
   input  logic [WIDTH-1:0] data_in,
   output logic             load_ready,
   output logic             serial_out,
   output logic             busy,
   output logic             done
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   state_t           state_q;
   logic [WIDTH-1:0] shreg_q;
   logic             cnt_zero;
   logic             xfer;

   assign busy       = (state_q == SHIFT);
   assign done       = busy && cnt_zero;
   // Ready during the last bit lets the next word follow with no gap.
   assign load_ready = (state_q == IDLE) || done;
   assign xfer       = load_valid && load_ready;
   // shreg is cleared in IDLE, so the MSB already reads 0 there; the gate
   // keeps the idle-low line explicit.
   assign serial_out = busy && shreg_q[WIDTH-1];

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= IDLE;
         shreg_q <= '0;
      end else if (xfer) begin
         state_q <= SHIFT;
         shreg_q <= data_in;
      end else if (state_q == SHIFT) begin
         if (!cnt_zero) begin
            shreg_q <= {shreg_q[WIDTH-2:0], 1'b0};
         end else begin
            state_q <= IDLE;
            shreg_q <= '0;
         end
      end
   end

   // A transfer in SHIFT only happens at count zero, so dec never
   // competes with load.
   bit_counter #(
      .W (CW)
   ) u_cnt (
      .clock      (clock),
      .reset      (reset),
      .load       (xfer),
      .load_value (CW'(WIDTH - 1)),
      .dec        (busy && !cnt_zero),
      .zero       (cnt_zero)
   );

endmodule

// File: tb/tb_shift_out_6.sv
module tb_shift_out_6;

   localparam int W = 6;

   logic         clock = 1'b0;
   logic         reset;
   logic         load_valid;
   logic [W-1:0] data_in;
   logic         load_ready, serial_out, busy, done;

   shift_out_6 #(.WIDTH(W)) dut (
      .clock      (clock),
      .reset      (reset),
      .load_valid (load_valid),
      .data_in    (data_in),
      .load_ready (load_ready),
      .serial_out (serial_out),
      .busy       (busy),
      .done       (done)
   );

   always #5 clock = ~clock;

   int tests = 0;
   int fails = 0;

   // Reference: index of the bit currently on the line, -1 when idle.
   int           m_idx = -1;
   logic [W-1:0] m_word = '0;

   // Loopback receiver and bit collection.
   logic [W-1:0] rx = '0;
   logic [15:0]  bits;
   int           nbits, ndone, nbusy;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Check one cycle against the model, then advance over one rising edge.
   task automatic tick();
      logic eb, es, ed, er, ser_s, acc;
      eb = (m_idx >= 0);
      es = eb ? m_word[m_idx] : 1'b0;
      ed = (m_idx == 0);
      er = !eb || ed;
      chk("busy", {31'b0, busy}, {31'b0, eb});
      chk("serial_out", {31'b0, serial_out}, {31'b0, es});
      chk("done", {31'b0, done}, {31'b0, ed});
      chk("load_ready", {31'b0, load_ready}, {31'b0, er});
      ser_s = serial_out;
      if (busy) begin
         bits = {bits[14:0], serial_out};
         nbits++;
         nbusy++;
      end
      if (done) ndone++;
      acc = load_valid && er;
      @(posedge clock);
      rx = {rx[W-2:0], ser_s};
      if (reset)            m_idx = -1;
      else if (acc) begin   m_word = data_in; m_idx = W - 1; end
      else if (m_idx >= 0)  m_idx--;
      #1;
   endtask

   task automatic clr();
      bits = '0; nbits = 0; ndone = 0; nbusy = 0;
   endtask

   initial begin
      logic hs;
      reset = 1'b1; load_valid = 1'b0; data_in = '0;
      clr();
      @(posedge clock); @(posedge clock); #1;
      m_idx = -1;
      reset = 1'b0;

      // Idle after reset.
      for (int i = 0; i < 10; i++) tick();

      // Single word with loopback receiver.
      load_valid = 1'b1; data_in = 6'b101101;
      tick();
      load_valid = 1'b0; data_in = 6'($urandom);
      clr();
      for (int i = 0; i < W; i++) tick();
      chk("single_bits", {26'b0, bits[5:0]}, 32'b101101);
      chk("single_done", ndone, 1);
      chk("loopback_rx", {26'b0, rx}, 32'b101101);
      tick();

      // Back-to-back words.
      load_valid = 1'b1; data_in = 6'b111000;
      tick();
      data_in = 6'b000111;
      clr();
      for (int i = 0; i < 2 * W; i++) begin
         if (i == W) load_valid = 1'b0;
         tick();
      end
      chk("b2b_bits", {20'b0, bits[11:0]}, 32'b111000000111);
      chk("b2b_done", ndone, 2);
      chk("b2b_busy", nbusy, 12);
      tick();

      // Load request while busy is held until the done cycle.
      load_valid = 1'b1; data_in = 6'b110011;
      tick();
      load_valid = 1'b0;
      clr();
      tick(); tick();
      load_valid = 1'b1; data_in = 6'b001100;
      for (int i = 0; i < 4; i++) tick();
      load_valid = 1'b0; data_in = 6'b111111;
      for (int i = 0; i < W; i++) tick();
      chk("ignore_bits", {20'b0, bits[11:0]}, 32'b110011001100);
      chk("ignore_done", ndone, 2);
      tick();

      // Reset mid-word.
      load_valid = 1'b1; data_in = 6'b111111;
      tick();
      load_valid = 1'b0;
      clr();
      tick(); tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("midrst_ser", {31'b0, serial_out}, 32'd0);
      chk("midrst_busy", {31'b0, busy}, 32'd0);
      chk("midrst_ready", {31'b0, load_ready}, 32'd1);
      for (int i = 0; i < 5; i++) tick();
      chk("midrst_done", ndone, 0);

      // Reset wins over a simultaneous handshake.
      reset = 1'b1; load_valid = 1'b1; data_in = 6'b100001;
      tick();
      reset = 1'b0; load_valid = 1'b0;
      clr();
      for (int i = 0; i < 8; i++) tick();
      chk("rsths_busy", nbusy, 0);

      // Randomized traffic; the producer holds its word until accepted.
      load_valid = 1'b0;
      for (int i = 0; i < 400; i++) begin
         hs = load_valid && load_ready;
         if (!load_valid || hs) begin
            load_valid = ($urandom_range(0, 3) != 0);
            data_in    = 6'($urandom);
         end
         reset = ($urandom_range(0, 49) == 0);
         tick();
      end
      reset = 1'b0; load_valid = 1'b0;
      for (int i = 0; i < 10; i++) tick();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/shift_out_6.md
# shift_out_6

Parallel-in, serial-out transmitter for the 6-bit left-shift serial link; the sending end for the 6-stage serial-in/parallel-out register. It accepts a parallel word through a valid/ready handshake and shifts it out MSB first, one bit per clock. After WIDTH clocks, a receiver fed from `serial_out` holds the word with its MSB in stage `a`. It sits between any word producer and the serial line.

## Interface
- `WIDTH`, default 6: word length in bits; must be ≥ 2.
- `clock`  in  1  Single clock; all state changes on the rising edge.
- `reset`  in  1  Synchronous, active-high reset. Sampled on the rising edge of `clock`.
- `load_valid`  in  1  Producer has a word on `data_in`.
- `data_in`  in  WIDTH  Word to transmit. Sampled only at handshake.
- `load_ready`  out  1  Transmitter can accept a word this cycle.
- `serial_out`  out  1  Line bit, MSB first.
- `busy`  out  1  High while a word is on the line.
- `done`  out  1  One-cycle pulse during the last bit of a word.

## Operation
- States: IDLE, SHIFT.
- Registers:
  - `shreg[WIDTH-1:0]`.
  - `count`, width clog2(WIDTH), counting remaining bits minus 1.
- Combinational outputs:
  - `serial_out = shreg[WIDTH-1]` in SHIFT; 0 in IDLE. The line idles low.
  - `busy = (state == SHIFT)`.
  - `done = (state == SHIFT && count == 0)`.
  - `load_ready = (state == IDLE) || done`.
- Handshake: a transfer occurs on a rising edge with `load_valid && load_ready`. On transfer: `shreg <= data_in`, `count <= WIDTH-1`, `state <= SHIFT`.
- SHIFT, `count != 0`: `shreg <= {shreg[WIDTH-2:0], 1'b0}`, `count <= count-1`.
- SHIFT, `count == 0`:
  - With a transfer: reload immediately. Back-to-back words, no gap bit.
  - Without a transfer: `state <= IDLE`, `shreg <= 0`.
- `load_valid` while `load_ready = 0` is ignored. The producer holds `data_in` and `load_valid` until it sees the handshake.
- `data_in` changes after the handshake do not affect the word in flight.

## Timing
- Reset values, applied on the edge where `reset = 1`: state IDLE, `shreg = 0`, `count = 0`. Resulting outputs: `serial_out = 0`, `busy = 0`, `done = 0`, `load_ready = 1`.
- Reset mid-word aborts the word. The remaining bits are never sent, and `done` does not pulse.
- `reset` has priority over a simultaneous handshake; that word is dropped.
- Latency: handshake on edge k puts bit WIDTH-1 on `serial_out` in the cycle after edge k. Bit 0 appears in the cycle after edge k+WIDTH-1, with `done = 1` in that same cycle.
- Throughput: one word per WIDTH cycles when `load_valid` is held high.
- The receiver samples `serial_out` on the rising edge. After WIDTH edges following the first bit cycle, receiver stages a..f equal `data_in[WIDTH-1:0]`.

## Structure
- Shared package holds:
  - `WIDTH_DEFAULT = 6`.
  - State enum `{IDLE, SHIFT}`, 1 bit.
  - `CNT_W = clog2(WIDTH)`.
- One sub-module, `bit_counter`: loadable down-counter with `load`, `load_value`, `dec`, `zero` ports and synchronous reset. It is shared with future framed serial blocks.
- The shift register and FSM stay in the top module.

## Test plan
- Reset then idle: `reset = 1` for 2 edges, then `load_valid = 0` for 10 cycles. Required: `serial_out = 0`, `busy = 0`, `done = 0`, `load_ready = 1` every cycle.
- Single word: `data_in = 6'b101101` with one handshake. Required:
  - `serial_out` = 1,0,1,1,0,1 on consecutive cycles.
  - `done = 1` only on the sixth bit, then IDLE with `serial_out = 0`.
  - Loopback receiver stages a..f read `101101`.
- Back-to-back: `load_valid` held high, `6'b111000` then `6'b000111`. Required: 12 contiguous bits `111000000111`, `done` pulses on cycles 6 and 12, `busy` stays high across the boundary.
- Ignore while busy: `6'b110011` loaded, then `load_valid = 1` with `6'b001100` at bit 3. Required:
  - `load_ready = 0` until the `done` cycle.
  - `110011` is sent intact.
  - `001100` is accepted at the `done` edge and sent next.
- Reset mid-word: load `6'b111111`, assert `reset` after bit 2. Required: the next cycle shows `serial_out = 0`, `busy = 0`, `load_ready = 1`, and no `done` pulse.
- Reset plus handshake on the same edge: `reset = 1` with `load_valid = 1` and `6'b100001`. Required: no transmission; the line stays 0.
